// File: rtl/mac_result_writer_if.sv
// Result-stream and RAM write-bus bundle for mac_result_writer.
//   in_valid / in_data / in_ready : 16-bit MAC result handshake (producer -> writer)
//   address / bus / wr            : registered RAM write port (writer -> RAM)
// master : the producer/RAM side; slave : the writer itself.
interface mac_result_writer_if #(
  parameter int word_size         = 16,
  parameter int bus_width         = 32,
  parameter int address_bus_width = 16
);
  logic                         in_valid;
  logic [word_size-1:0]         in_data;
  logic                         in_ready;
  logic [address_bus_width-1:0] address;
  logic [bus_width-1:0]         bus;
  logic                         wr;

  modport master (
    output in_valid, in_data,
    input  in_ready, address, bus, wr
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, address, bus, wr
  );
endinterface

// File: rtl/mac_result_writer.sv
// mac_result_writer: packs 16-bit MAC results two per 32-bit word (first
// result in the upper half) and writes the words to RAM at sequential,
// wrapping addresses starting from a base latched on start.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   start      : one-cycle job start (honoured only when idle)
//   base_addr  : first write address, reduced modulo memory_size on latch
//   io (slave) : in_valid/in_data/in_ready result handshake,
//                address/bus/wr registered write port
//   busy       : job in progress
//   done       : one-cycle pulse the cycle after the final write
module mac_result_writer #(
  parameter int word_size         = 16,
  parameter int bus_width         = 32,
  parameter int address_bus_width = 16,
  parameter int memory_size       = 12,
  parameter int num_results       = 12,
  parameter int fifo_depth        = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [address_bus_width-1:0] base_addr,
  mac_result_writer_if.slave           io,
  output logic                         busy,
  output logic                         done
);

  localparam int num_words = (num_results + 1) / 2;
  localparam int acc_w     = $clog2(num_results + 1);
  localparam int wcnt_w    = $clog2(num_words + 1);
  localparam int ptr_w     = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam int cnt_w     = $clog2(fifo_depth + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                       state, state_next;

  logic [acc_w-1:0]             acc_cnt;
  logic [wcnt_w-1:0]            wr_cnt;
  logic                         half;
  logic [word_size-1:0]         hi;
  logic [bus_width-1:0]         mem [fifo_depth];
  logic [ptr_w-1:0]             rd_ptr, wr_ptr;
  logic [cnt_w-1:0]             fifo_cnt;
  logic [address_bus_width-1:0] waddr;

  logic [address_bus_width-1:0] address_q;
  logic [bus_width-1:0]         bus_q;
  logic                         wr_q;
  logic                         done_q;

  logic                         in_ready_c;
  logic                         xfer, last, push, pop, bypass, fifo_write, emit;
  logic                         start_job, done_next;
  logic [bus_width-1:0]         push_word, emit_word;

  always_comb begin
    in_ready_c = 1'b0;
    if (state == RUN)
      in_ready_c = (acc_cnt < acc_w'(num_results)) && (fifo_cnt < cnt_w'(fifo_depth));

    xfer = io.in_valid && in_ready_c;
    last = xfer && (acc_cnt == acc_w'(num_results - 1));
    // An odd final result has no partner; it is padded with zeros below.
    push = xfer && (half || last);
    push_word = half ? {hi, io.in_data} : {io.in_data, {word_size{1'b0}}};

    // The output register acts as the FIFO head: a word pushed into an
    // empty FIFO goes straight to the bus on the same edge.
    pop        = (fifo_cnt != '0);
    bypass     = push && !pop;
    fifo_write = push && !bypass;
    emit       = pop || bypass;
    emit_word  = pop ? mem[rd_ptr] : push_word;

    state_next = state;
    start_job  = 1'b0;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          start_job  = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (last) state_next = DRAIN;
      end
      DRAIN: begin
        if (wr_cnt == wcnt_w'(num_words)) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_cnt   <= '0;
      wr_cnt    <= '0;
      half      <= 1'b0;
      hi        <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      fifo_cnt  <= '0;
      waddr     <= '0;
      address_q <= '0;
      bus_q     <= '0;
      wr_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      wr_q   <= 1'b0;
      done_q <= done_next;
      if (start_job) begin
        waddr    <= address_bus_width'(int'(base_addr) % memory_size);
        acc_cnt  <= '0;
        wr_cnt   <= '0;
        half     <= 1'b0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        fifo_cnt <= '0;
      end else begin
        if (xfer) begin
          acc_cnt <= acc_cnt + 1'b1;
          if (!half && !last) begin
            hi   <= io.in_data;
            half <= 1'b1;
          end else begin
            half <= 1'b0;
          end
        end

        if (fifo_write) wr_ptr <= wr_ptr + 1'b1;
        if (pop)        rd_ptr <= rd_ptr + 1'b1;
        if (fifo_write && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
        else if (pop && !fifo_write) fifo_cnt <= fifo_cnt - 1'b1;

        if (emit) begin
          wr_q      <= 1'b1;
          bus_q     <= emit_word;
          address_q <= waddr;
          waddr     <= (waddr == address_bus_width'(memory_size - 1)) ? '0 : waddr + 1'b1;
          wr_cnt    <= wr_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_write) mem[wr_ptr] <= push_word;
  end

  assign io.in_ready = in_ready_c;
  assign io.address  = address_q;
  assign io.bus      = bus_q;
  assign io.wr       = wr_q;
  assign busy        = (state != IDLE);
  assign done        = done_q;

endmodule

// File: tb/tb_mac_result_writer.sv
module tb_mac_result_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic [15:0] base_addr = '0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        busy0, done0, busy1, done1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mac_result_writer_if #(.word_size(16), .bus_width(32), .address_bus_width(16)) if0();
  mac_result_writer_if #(.word_size(16), .bus_width(32), .address_bus_width(16)) if1();

  assign if0.in_valid = in_valid;
  assign if0.in_data  = in_data;
  assign if1.in_valid = in_valid;
  assign if1.in_data  = in_data;

  mac_result_writer u0 (
    .clk(clk), .rst(rst), .start(start0), .base_addr(base_addr),
    .io(if0), .busy(busy0), .done(done0)
  );

  mac_result_writer #(.num_results(5), .fifo_depth(2)) u1 (
    .clk(clk), .rst(rst), .start(start1), .base_addr(base_addr),
    .io(if1), .busy(busy1), .done(done1)
  );

  logic [15:0] qa0[$], qa1[$];
  logic [31:0] qd0[$], qd1[$];
  int          done_n0 = 0, done_n1 = 0;

  always @(negedge clk) begin
    if (if0.wr) begin qa0.push_back(if0.address); qd0.push_back(if0.bus); end
    if (if1.wr) begin qa1.push_back(if1.address); qd1.push_back(if1.bus); end
    if (done0) done_n0++;
    if (done1) done_n1++;
  end

  logic [15:0] stim [16];
  logic [15:0] vpat;

  task automatic clear_mon();
    qa0.delete(); qd0.delete(); qa1.delete(); qd1.delete();
    done_n0 = 0; done_n1 = 0;
  endtask

  // Entered and left at posedge+1. Returns cycles spent streaming.
  task automatic run_stream(input int which, input logic [15:0] base, input int n,
                            input int restart_at, output int cycles);
    int idx, cyc;
    logic rdy, acc;
    base_addr = base;
    start0 = (which == 0);
    start1 = (which == 1);
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0;
    idx = 0; cyc = 0;
    while (idx < n && cyc < 100) begin
      in_valid = vpat[cyc % 16];
      in_data  = stim[idx];
      if (cyc == restart_at) begin
        start0 = (which == 0); start1 = (which == 1); base_addr = 16'd8;
      end
      @(negedge clk);
      rdy = (which == 0) ? if0.in_ready : if1.in_ready;
      acc = in_valid && rdy;
      @(posedge clk); #1;
      start0 = 1'b0; start1 = 1'b0;
      if (acc) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    in_data  = '0;
    cycles = cyc;
  endtask

  task automatic wait_done(input int which, output int lat);
    logic d;
    lat = 0; d = 1'b0;
    while (!d && lat < 20) begin
      @(negedge clk);
      lat++;
      d = (which == 0) ? done0 : done1;
    end
  endtask

  task automatic load_counting();
    for (int i = 0; i < 16; i++) stim[i] = 16'(i + 1);
    vpat = 16'hFFFF;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (if0.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", if0.in_ready); end
    checks++; if (if0.address !== 16'h0) begin errors++; $display("FAIL reset_address: got %h expected 0000", if0.address); end
    checks++; if (if0.bus !== 32'h0) begin errors++; $display("FAIL reset_bus: got %h expected 00000000", if0.bus); end
    checks++; if (if0.wr !== 1'b0) begin errors++; $display("FAIL reset_wr: got %b expected 0", if0.wr); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy0); end
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done0); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_idle_quiescence();
    clear_mon();
    in_valid = 1'b1; in_data = 16'h5555;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (if0.in_ready !== 1'b0) begin errors++; $display("FAIL idle_in_ready: got %b expected 0", if0.in_ready); end
      checks++; if (if0.wr !== 1'b0) begin errors++; $display("FAIL idle_wr: got %b expected 0", if0.wr); end
      checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy0); end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Checks qa0/qd0 against the 1..12 counting job starting at first_addr.
  task automatic test_even();
    int cyc, lat;
    clear_mon(); load_counting();
    run_stream(0, 16'd0, 12, -1, cyc);
    checks++; if (cyc != 12) begin errors++; $display("FAIL even_stream_cycles: got %0d expected 12", cyc); end
    wait_done(0, lat);
    checks++; if (lat > 6) begin errors++; $display("FAIL even_done_latency: got %0d expected <=6", lat); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL even_busy_at_done: got %b expected 0", busy0); end
    @(negedge clk);
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL even_done_width: got %b expected 0", done0); end
    checks++; if (done_n0 != 1) begin errors++; $display("FAIL even_done_count: got %0d expected 1", done_n0); end
    checks++;
    if (qa0.size() != 6) begin
      errors++; $display("FAIL even_write_count: got %0d expected 6", qa0.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (qa0[i] !== 16'(i) || qd0[i] !== {16'(2*i+1), 16'(2*i+2)}) begin
          errors++;
          $display("FAIL even_write[%0d]: got %h/%h expected %h/%h", i, qa0[i], qd0[i], 16'(i), {16'(2*i+1), 16'(2*i+2)});
        end
      end
    end
    checks++; if (if0.address !== 16'd5 || if0.bus !== 32'h000B000C) begin
      errors++; $display("FAIL even_hold: got %h/%h expected 0005/000b000c", if0.address, if0.bus);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_odd();
    int cyc, lat;
    logic [31:0] exp_d [3];
    exp_d[0] = 32'hAAAABBBB; exp_d[1] = 32'hCCCCDDDD; exp_d[2] = 32'hEEEE0000;
    clear_mon();
    stim[0] = 16'hAAAA; stim[1] = 16'hBBBB; stim[2] = 16'hCCCC; stim[3] = 16'hDDDD; stim[4] = 16'hEEEE;
    vpat = 16'hFFFF;
    run_stream(1, 16'd3, 5, -1, cyc);
    wait_done(1, lat);
    checks++; if (done1 !== 1'b1) begin errors++; $display("FAIL odd_done: got %b expected 1", done1); end
    @(negedge clk);
    checks++;
    if (qa1.size() != 3) begin
      errors++; $display("FAIL odd_write_count: got %0d expected 3", qa1.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (qa1[i] !== 16'(3 + i) || qd1[i] !== exp_d[i]) begin
          errors++; $display("FAIL odd_write[%0d]: got %h/%h expected %h/%h", i, qa1[i], qd1[i], 16'(3 + i), exp_d[i]);
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    int cyc, lat;
    logic [15:0] exp_a [6];
    exp_a[0] = 16'd10; exp_a[1] = 16'd11; exp_a[2] = 16'd0;
    exp_a[3] = 16'd1;  exp_a[4] = 16'd2;  exp_a[5] = 16'd3;
    clear_mon(); load_counting();
    run_stream(0, 16'd10, 12, -1, cyc);
    wait_done(0, lat);
    @(negedge clk);
    checks++;
    if (qa0.size() != 6) begin
      errors++; $display("FAIL wrap_write_count: got %0d expected 6", qa0.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (qa0[i] !== exp_a[i]) begin
          errors++; $display("FAIL wrap_addr[%0d]: got %h expected %h", i, qa0[i], exp_a[i]);
        end
      end
    end
    @(posedge clk); #1;
    // Base beyond memory_size is reduced modulo 12: 14 -> 2.
    clear_mon();
    run_stream(0, 16'd14, 12, -1, cyc);
    wait_done(0, lat);
    @(negedge clk);
    checks++;
    if (qa0.size() != 6 || qa0[0] !== 16'd2 || qa0[5] !== 16'd7) begin
      errors++; $display("FAIL wrap_base_mod: got size %0d first %h expected size 6 first 0002 last 0007", qa0.size(), (qa0.size() > 0) ? qa0[0] : 16'hxxxx);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int cyc, lat;
    logic [31:0] exp_d [3];
    logic [15:0] exp_a [3];
    exp_d[0] = 32'h10011002; exp_d[1] = 32'h10031004; exp_d[2] = 32'h10050000;
    exp_a[0] = 16'd11; exp_a[1] = 16'd0; exp_a[2] = 16'd1;
    clear_mon();
    for (int i = 0; i < 5; i++) stim[i] = 16'h1001 + 16'(i);
    vpat = 16'b0110_1001_1100_1010;
    run_stream(1, 16'd11, 5, -1, cyc);
    wait_done(1, lat);
    checks++; if (lat > 4) begin errors++; $display("FAIL bp_done_latency: got %0d expected <=4", lat); end
    @(negedge clk);
    checks++; if (done_n1 != 1) begin errors++; $display("FAIL bp_done_count: got %0d expected 1", done_n1); end
    checks++;
    if (qa1.size() != 3) begin
      errors++; $display("FAIL bp_write_count: got %0d expected 3", qa1.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (qa1[i] !== exp_a[i] || qd1[i] !== exp_d[i]) begin
          errors++; $display("FAIL bp_write[%0d]: got %h/%h expected %h/%h", i, qa1[i], qd1[i], exp_a[i], exp_d[i]);
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_start_during_job();
    int cyc, lat;
    clear_mon(); load_counting();
    run_stream(0, 16'd0, 12, 3, cyc);
    wait_done(0, lat);
    @(negedge clk);
    checks++;
    if (qa0.size() != 6) begin
      errors++; $display("FAIL restart_write_count: got %0d expected 6", qa0.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (qa0[i] !== 16'(i) || qd0[i] !== {16'(2*i+1), 16'(2*i+2)}) begin
          errors++; $display("FAIL restart_write[%0d]: got %h/%h expected %h/%h", i, qa0[i], qd0[i], 16'(i), {16'(2*i+1), 16'(2*i+2)});
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_job();
    int k, cyc, lat;
    clear_mon();
    base_addr = 16'd0; start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; in_valid = 1'b1;
    k = 0;
    while (k < 40) begin
      in_data = 16'(k + 1);
      @(negedge clk); #1;
      if (qa0.size() >= 3) break;
      @(posedge clk); #1;
      k++;
    end
    checks++; if (k >= 40) begin errors++; $display("FAIL midrst_third_write_timeout: got %0d writes expected 3", qa0.size()); end
    rst = 1'b1;
    #1;
    checks++; if (if0.wr !== 1'b0) begin errors++; $display("FAIL midrst_wr: got %b expected 0", if0.wr); end
    checks++; if (if0.address !== 16'h0 || if0.bus !== 32'h0) begin
      errors++; $display("FAIL midrst_addr_bus: got %h/%h expected 0000/00000000", if0.address, if0.bus);
    end
    checks++; if (busy0 !== 1'b0 || done0 !== 1'b0 || if0.in_ready !== 1'b0) begin
      errors++; $display("FAIL midrst_status: got busy %b done %b ready %b expected 0 0 0", busy0, done0, if0.in_ready);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (qa0.size() != 3) begin errors++; $display("FAIL midrst_no_more_writes: got %0d expected 3", qa0.size()); end
    clear_mon(); load_counting();
    run_stream(0, 16'd0, 12, -1, cyc);
    wait_done(0, lat);
    checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL midrst_clean_done: got %b expected 1", done0); end
    @(negedge clk);
    checks++;
    if (qa0.size() != 6) begin
      errors++; $display("FAIL midrst_clean_count: got %0d expected 6", qa0.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (qa0[i] !== 16'(i) || qd0[i] !== {16'(2*i+1), 16'(2*i+2)}) begin
          errors++; $display("FAIL midrst_clean_write[%0d]: got %h/%h expected %h/%h", i, qa0[i], qd0[i], 16'(i), {16'(2*i+1), 16'(2*i+2)});
        end
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_idle_quiescence();
    test_even();
    test_odd();
    test_wrap();
    test_backpressure();
    test_start_during_job();
    test_reset_mid_job();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
